// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit
//   Stall/flush controller for the 5-stage pipeline. It handles the hazards
//   that forwarding cannot hide:
//     - load-use dependencies, by inserting one bubble;
//     - taken branches, by flushing IF/ID and ID/EX;
//     - multi-cycle data-memory accesses, by freezing the whole pipe.
//   It also keeps saturating stall and flush counters.
// Ports
//   clk, rstn                     clock, async active-low reset
//   readAddr1/2_ID, useRs1/2_ID   ID source operands and their use flags
//   memWrite_ID                   ID instruction is a store
//   memRead_EX, writeAddr_EX      EX load and its destination
//   branchTaken_EX                EX redirect
//   memReq_MEM, memReady          data-memory handshake
//   stall*/flush*/bubbleMEMWB     pipeline register controls (combinational)
//   memWaiting, memTimeout        wait FSM status (registered)
//   stallCycles, flushCount       saturating performance counters
module hazard_stall_unit #(
  parameter int REG_IDX_WIDTH = 5,
  parameter int CNT_WIDTH     = 32,
  parameter int MEM_TIMEOUT   = 255
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [REG_IDX_WIDTH-1:0] readAddr1_ID,
  input  logic [REG_IDX_WIDTH-1:0] readAddr2_ID,
  input  logic                     useRs1_ID,
  input  logic                     useRs2_ID,
  input  logic                     memWrite_ID,
  input  logic                     memRead_EX,
  input  logic [REG_IDX_WIDTH-1:0] writeAddr_EX,
  input  logic                     branchTaken_EX,
  input  logic                     memReq_MEM,
  input  logic                     memReady,
  output logic                     stallPC,
  output logic                     stallIFID,
  output logic                     flushIFID,
  output logic                     stallIDEX,
  output logic                     flushIDEX,
  output logic                     stallEXMEM,
  output logic                     bubbleMEMWB,
  output logic                     memWaiting,
  output logic                     memTimeout,
  output logic [CNT_WIDTH-1:0]     stallCycles,
  output logic [CNT_WIDTH-1:0]     flushCount
);

  localparam int WCW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCW-1:0] WAIT_MAX = WCW'(MEM_TIMEOUT);

  typedef enum logic {ST_RUN, ST_WAIT} state_e;

  state_e               state_q, state_d;
  logic [WCW-1:0]       wait_cnt_q, wait_cnt_d;
  logic                 timeout_q, timeout_d;
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

  logic load_use, mem_stall, br_flush, lu_stall;

  // A store matching only on rs2 gets its data forwarded WB->MEM, so it
  // does not need the bubble.
  always_comb begin
    load_use  = memRead_EX && (writeAddr_EX != '0) &&
                ((useRs1_ID && (readAddr1_ID == writeAddr_EX)) ||
                 (useRs2_ID && (readAddr2_ID == writeAddr_EX) && !memWrite_ID));
    mem_stall = memReq_MEM && !memReady;
    br_flush  = branchTaken_EX && !mem_stall;
    lu_stall  = load_use && !branchTaken_EX && !mem_stall;
  end

  // Control outputs are gated by rstn so that they drop the instant reset
  // is asserted, even with hazard inputs still active.
  always_comb begin
    stallPC     = 1'b0;
    stallIFID   = 1'b0;
    flushIFID   = 1'b0;
    stallIDEX   = 1'b0;
    flushIDEX   = 1'b0;
    stallEXMEM  = 1'b0;
    bubbleMEMWB = 1'b0;
    if (rstn) begin
      if (mem_stall) begin
        stallPC     = 1'b1;
        stallIFID   = 1'b1;
        stallIDEX   = 1'b1;
        stallEXMEM  = 1'b1;
        bubbleMEMWB = 1'b1;
      end else if (br_flush) begin
        flushIFID   = 1'b1;
        flushIDEX   = 1'b1;
      end else if (lu_stall) begin
        stallPC     = 1'b1;
        stallIFID   = 1'b1;
        flushIDEX   = 1'b1;
      end
    end
  end

  // Wait FSM. Leaving WAIT happens on the first cycle the freeze is not
  // needed (normally memReady), so the completing cycle is not frozen.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      ST_RUN: begin
        if (mem_stall) begin
          state_d    = ST_WAIT;
          wait_cnt_d = WCW'(1);
        end
      end
      ST_WAIT: begin
        if (mem_stall) begin
          if (wait_cnt_q != WAIT_MAX) wait_cnt_d = wait_cnt_q + WCW'(1);
        end else begin
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end
      end
      default: begin
        state_d    = ST_RUN;
        wait_cnt_d = '0;
      end
    endcase
    timeout_d = timeout_q || ((state_d == ST_WAIT) && (wait_cnt_d == WAIT_MAX));
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if ((mem_stall || lu_stall) && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
    if (br_flush && (flush_cnt_q != '1))
      flush_cnt_d = flush_cnt_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_RUN;
      wait_cnt_q  <= '0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      timeout_q   <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign memWaiting  = (state_q == ST_WAIT);
  assign memTimeout  = timeout_q;
  assign stallCycles = stall_cnt_q;
  assign flushCount  = flush_cnt_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Bench for hazard_stall_unit: directed vectors, a behavioural model checked
// on every falling edge, and literal expectations at key points.
module tb_hazard_stall_unit;

  localparam int RW  = 5;
  localparam int CW  = 4;
  localparam int MTO = 4;

  logic          clk = 1'b0;
  logic          rstn;
  logic [RW-1:0] readAddr1_ID, readAddr2_ID, writeAddr_EX;
  logic          useRs1_ID, useRs2_ID, memWrite_ID, memRead_EX;
  logic          branchTaken_EX, memReq_MEM, memReady;
  logic          stallPC, stallIFID, flushIFID, stallIDEX, flushIDEX;
  logic          stallEXMEM, bubbleMEMWB, memWaiting, memTimeout;
  logic [CW-1:0] stallCycles, flushCount;

  hazard_stall_unit #(.REG_IDX_WIDTH(RW), .CNT_WIDTH(CW), .MEM_TIMEOUT(MTO)) dut (
    .clk(clk), .rstn(rstn),
    .readAddr1_ID(readAddr1_ID), .readAddr2_ID(readAddr2_ID),
    .useRs1_ID(useRs1_ID), .useRs2_ID(useRs2_ID), .memWrite_ID(memWrite_ID),
    .memRead_EX(memRead_EX), .writeAddr_EX(writeAddr_EX),
    .branchTaken_EX(branchTaken_EX), .memReq_MEM(memReq_MEM), .memReady(memReady),
    .stallPC(stallPC), .stallIFID(stallIFID), .flushIFID(flushIFID),
    .stallIDEX(stallIDEX), .flushIDEX(flushIDEX), .stallEXMEM(stallEXMEM),
    .bubbleMEMWB(bubbleMEMWB), .memWaiting(memWaiting), .memTimeout(memTimeout),
    .stallCycles(stallCycles), .flushCount(flushCount)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Control vector order: stallPC stallIFID flushIFID stallIDEX flushIDEX stallEXMEM bubbleMEMWB
  localparam logic [6:0] C_NONE   = 7'b0000000;
  localparam logic [6:0] C_LU     = 7'b1100100;
  localparam logic [6:0] C_BR     = 7'b0010100;
  localparam logic [6:0] C_FREEZE = 7'b1101011;

  wire [6:0] ctl = {stallPC, stallIFID, flushIFID, stallIDEX, flushIDEX, stallEXMEM, bubbleMEMWB};

  // ---------------- behavioural model ----------------
  function automatic logic m_load_use();
    return memRead_EX && writeAddr_EX != 0 &&
           ((useRs1_ID && readAddr1_ID == writeAddr_EX) ||
            (useRs2_ID && readAddr2_ID == writeAddr_EX && !memWrite_ID));
  endfunction

  function automatic logic [6:0] m_ctl();
    if (!rstn)                        return C_NONE;
    if (memReq_MEM && !memReady)      return C_FREEZE;
    if (branchTaken_EX)               return C_BR;
    if (m_load_use())                 return C_LU;
    return C_NONE;
  endfunction

  // Wait tracking as a run length of consecutive frozen cycles; the flag is
  // set once any run has reached MTO cycles.
  int m_run, m_stall, m_flush;
  bit m_to;
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_run <= 0; m_stall <= 0; m_flush <= 0; m_to <= 0;
    end else begin
      m_run <= (memReq_MEM && !memReady) ? m_run + 1 : 0;
      if (memReq_MEM && !memReady && m_run + 1 >= MTO) m_to <= 1;
      if (m_ctl() == C_FREEZE || m_ctl() == C_LU) m_stall <= (m_stall >= 15) ? 15 : m_stall + 1;
      if (m_ctl() == C_BR) m_flush <= (m_flush >= 15) ? 15 : m_flush + 1;
    end
  end

  always @(negedge clk) begin
    chk("m_ctl",        32'(ctl),         32'(m_ctl()));
    chk("m_memWaiting", 32'(memWaiting),  32'(m_run > 0));
    chk("m_memTimeout", 32'(memTimeout),  32'(m_to));
    chk("m_stallCycles",32'(stallCycles), 32'(m_stall));
    chk("m_flushCount", 32'(flushCount),  32'(m_flush));
  end

  // ---------------- directed stimulus ----------------
  task automatic idle();
    readAddr1_ID = 0; readAddr2_ID = 0; writeAddr_EX = 0;
    useRs1_ID = 0; useRs2_ID = 0; memWrite_ID = 0; memRead_EX = 0;
    branchTaken_EX = 0; memReq_MEM = 0; memReady = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #3 rstn = 0;
    idle();
    tick(); tick();
    #2 rstn = 1;
    tick();
  endtask

  initial begin
    rstn = 0;
    idle();
    tick(); tick();
    chk("rst_ctl",   32'(ctl), 32'(C_NONE));
    chk("rst_wait",  32'(memWaiting), 0);
    chk("rst_cnt",   32'({stallCycles, flushCount}), 0);
    #2 rstn = 1;
    tick();

    // Load x5 in EX, add reads x5: one bubble, then clear.
    memRead_EX = 1; writeAddr_EX = 5; useRs1_ID = 1; readAddr1_ID = 5;
    #1 chk("lu_ctl", 32'(ctl), 32'(C_LU));
    tick();
    memRead_EX = 0; writeAddr_EX = 0;
    #1 chk("lu_after", 32'(ctl), 32'(C_NONE));
    chk("lu_stallcnt", 32'(stallCycles), 1);

    // Store with rs2 match only: no stall; with rs1 match: stall.
    memRead_EX = 1; writeAddr_EX = 5; useRs1_ID = 1; readAddr1_ID = 2;
    useRs2_ID = 1; readAddr2_ID = 5; memWrite_ID = 1;
    #1 chk("st_rs2", 32'(ctl), 32'(C_NONE));
    readAddr1_ID = 5;
    #1 chk("st_rs1", 32'(ctl), 32'(C_LU));
    tick();
    idle();

    // Branch together with a load-use match: flush wins.
    memRead_EX = 1; writeAddr_EX = 7; useRs2_ID = 1; readAddr2_ID = 7;
    branchTaken_EX = 1;
    #1 chk("br_lu", 32'(ctl), 32'(C_BR));
    tick();
    idle();
    #1 chk("br_flushcnt", 32'(flushCount), 1);
    chk("br_stallcnt", 32'(stallCycles), 2);

    // x0 destination never stalls.
    memRead_EX = 1; writeAddr_EX = 0; useRs1_ID = 1; readAddr1_ID = 0;
    #1 chk("x0_nostall", 32'(ctl), 32'(C_NONE));
    tick();
    idle();

    // 3-cycle memory wait; branch during the freeze is ignored.
    memReq_MEM = 1; memReady = 0;
    #1 chk("mw_c1", 32'(ctl), 32'(C_FREEZE));
    chk("mw_c1_wait", 32'(memWaiting), 0);
    tick();
    branchTaken_EX = 1;
    #1 chk("mw_c2_br", 32'(ctl), 32'(C_FREEZE));
    chk("mw_c2_wait", 32'(memWaiting), 1);
    tick();
    branchTaken_EX = 0;
    tick();
    memReady = 1;
    #1 chk("mw_c4", 32'(ctl), 32'(C_NONE));
    chk("mw_c4_wait", 32'(memWaiting), 1);
    tick();
    idle();
    #1 chk("mw_done_wait", 32'(memWaiting), 0);
    chk("mw_stallcnt", 32'(stallCycles), 5);
    chk("mw_flushcnt", 32'(flushCount), 1);

    // Timeout after the 4th wait edge, sticky, then async reset mid-wait.
    do_reset();
    memReq_MEM = 1; memReady = 0;
    tick(); tick(); tick();
    chk("to_before", 32'(memTimeout), 0);
    tick();
    chk("to_at4", 32'(memTimeout), 1);
    tick(); tick();
    memReady = 1;
    tick();
    chk("to_sticky", 32'(memTimeout), 1);
    chk("to_run", 32'(memWaiting), 0);
    memReady = 0;
    tick(); tick();
    #3 rstn = 0;
    #1 chk("arst_ctl", 32'(ctl), 32'(C_NONE));
    chk("arst_wait", 32'(memWaiting), 0);
    chk("arst_to", 32'(memTimeout), 0);
    chk("arst_cnt", 32'(stallCycles), 0);
    idle();
    tick();
    #2 rstn = 1;
    tick();

    // Counter saturation.
    branchTaken_EX = 1;
    repeat (20) tick();
    branchTaken_EX = 0;
    #1 chk("flush_sat", 32'(flushCount), 15);
    memReq_MEM = 1;
    repeat (20) tick();
    memReady = 1;
    #1 chk("stall_sat", 32'(stallCycles), 15);
    tick();
    idle();
    tick();

    @(posedge clk); #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected done");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Stall/flush controller for the 5-stage pipeline.
- Covers the hazards that operand forwarding cannot resolve:
  - load-use dependencies (one-cycle bubble);
  - taken-branch redirects (flush of the two younger stages);
  - multi-cycle data-memory accesses (full pipeline freeze, with a wait-state FSM and timeout).
- Sits beside the forwarding logic and drives the enable and flush inputs of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Keeps saturating performance counters.

Parameters:
- REG_IDX_WIDTH, 5, register index width.
- CNT_WIDTH, 32, width of the performance counters.
- MEM_TIMEOUT, 255, number of consecutive wait cycles before memTimeout is raised (must be ≥1).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rstn  in  1  asynchronous active-low reset.
- readAddr1_ID  in  REG_IDX_WIDTH  rs1 of the instruction in ID.
- readAddr2_ID  in  REG_IDX_WIDTH  rs2 of the instruction in ID.
- useRs1_ID  in  1  ID instruction reads rs1.
- useRs2_ID  in  1  ID instruction reads rs2.
- memWrite_ID  in  1  ID instruction is a store.
- memRead_EX  in  1  EX instruction is a load.
- writeAddr_EX  in  REG_IDX_WIDTH  rd of the EX instruction.
- branchTaken_EX  in  1  EX resolved a taken branch or jump.
- memReq_MEM  in  1  MEM stage is issuing a data-memory access.
- memReady  in  1  data memory completes the access this cycle.
- stallPC  out  1  hold the PC.
- stallIFID  out  1  hold the IF/ID register.
- flushIFID  out  1  load a bubble into IF/ID.
- stallIDEX  out  1  hold the ID/EX register.
- flushIDEX  out  1  load a bubble into ID/EX.
- stallEXMEM  out  1  hold the EX/MEM register.
- bubbleMEMWB  out  1  load a bubble into MEM/WB.
- memWaiting  out  1  FSM is in WAIT (registered).
- memTimeout  out  1  sticky timeout flag.
- stallCycles  out  CNT_WIDTH  count of stall cycles.
- flushCount  out  CNT_WIDTH  count of branch flushes.

Behaviour:
- Reset is asynchronous and active-low; clk is the single clock.
- While rstn=0:
  - all control outputs are 0;
  - FSM is in RUN; the wait counter, memTimeout, stallCycles and flushCount are 0.
- Hazard terms (combinational; same-cycle response, zero latency):
  - loadUse = memRead_EX && writeAddr_EX != 0 && ((useRs1_ID && readAddr1_ID == writeAddr_EX) || (useRs2_ID && readAddr2_ID == writeAddr_EX && !memWrite_ID)).
  - A store whose only match is on rs2 does not stall; its data is forwarded WB→MEM.
  - memStall = memReq_MEM && !memReady.
- Priority, highest first:
  1. memStall: stallPC = stallIFID = stallIDEX = stallEXMEM = 1 and bubbleMEMWB = 1.
     - Branch and load-use terms are ignored this cycle. They are re-evaluated once the freeze releases, because the EX contents are held.
  2. branchTaken_EX: flushIFID = flushIDEX = 1; no stalls.
     - Flush wins over a simultaneous loadUse, since the dependent instruction is discarded.
  3. loadUse: stallPC = stallIFID = 1, flushIDEX = 1.
     - Exactly one bubble is inserted. The next cycle the load is in MEM and no longer matches.
  4. Otherwise all outputs are 0.
- FSM states: RUN, WAIT.
  - RUN→WAIT when memStall; the wait counter is loaded with 1.
  - WAIT→WAIT while memStall; the wait counter increments and saturates at MEM_TIMEOUT.
  - WAIT→RUN when memReady=1 (the completing cycle is not frozen); the wait counter is cleared.
  - memWaiting = (state == WAIT).
- memTimeout is set on the edge where the wait counter reaches MEM_TIMEOUT while still in WAIT.
  - It is cleared only by reset. The freeze continues regardless of the flag.
- stallCycles increments by 1 in every cycle where memStall or a priority-3 loadUse stall is active.
- flushCount increments by 1 in every priority-2 cycle.
- Both counters saturate at all-ones and do not wrap.
- A reset asserted mid-wait forces RUN and drops all outputs immediately (asynchronous).
- writeAddr_EX == 0 never causes a stall.

Test Plan:
- Load x5 in EX (memRead_EX=1, writeAddr_EX=5); ID add reads rs1=5 → one cycle with stallPC=stallIFID=flushIDEX=1; next cycle all 0; stallCycles=1.
- Load x5 in EX; ID is a store with rs2=5, rs1=2, memWrite_ID=1 → no stall, all outputs 0. Same case with rs1=5 → stall.
- branchTaken_EX=1 together with a loadUse match → flushIFID=flushIDEX=1, stallPC=0; flushCount=1, stallCycles unchanged.
- memReq_MEM=1 with memReady low for 3 cycles, then high → 3 cycles of full freeze plus bubbleMEMWB, memWaiting=1 for cycles 2–4, then RUN; stallCycles=3.
- MEM_TIMEOUT=4 with memReady held low for 6 cycles → memTimeout rises after the 4th wait edge and stays 1 after memReady returns; rstn pulsed low mid-wait → all outputs 0 asynchronously and the FSM is in RUN.
- CNT_WIDTH=4 with 20 consecutive branch flushes → flushCount holds 15.
